// File: rtl/cpu16_pkg.sv
// Shared encodings for the 16-bit multi-cycle CPU control path:
// opcodes, FSM states, datapath mux/ALU encodings and fault codes.
package cpu16_pkg;

    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_LW    = 4'b0100;
    localparam logic [3:0] OP_SW    = 4'b0101;
    localparam logic [3:0] OP_BEQ   = 4'b0110;
    localparam logic [3:0] OP_ADDI  = 4'b0111;
    localparam logic [3:0] OP_J     = 4'b1000;
    localparam logic [3:0] OP_HALT  = 4'b1111;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC_R, S_WB_R, S_EXEC_I, S_WB_I,
        S_MEM_ADDR, S_MEM_RD, S_WB_MEM, S_MEM_WR, S_BRANCH, S_JUMP,
        S_HALT, S_FAULT
    } state_t;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REGB = 2'b00;
    localparam logic [1:0] SRCB_ONE  = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] FAULT_NONE    = 2'b00;
    localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
    localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive not-ready memory cycles; expired_o flags the
// MEM_TIMEOUT-th such cycle combinationally so the FSM can fault on it.
module mem_wait_timer #(
    parameter int unsigned MEM_TIMEOUT = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic inc_i,
    output logic expired_o
);

    localparam logic [7:0] LAST = 8'(MEM_TIMEOUT - 1);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i)
            cnt_d = '0;
        else if (inc_i)
            cnt_d = cnt_q + 8'd1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign expired_o = inc_i && (cnt_q == LAST);

endmodule

// File: rtl/cpu16_mc_ctrl.sv
// Multi-cycle control FSM for the 16-bit CPU: sequences fetch, decode,
// execute, memory and writeback, with memory wait timeout and fault codes.
module cpu16_mc_ctrl
    import cpu16_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 8,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic [3:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_read,
    output logic             mem_write,
    output logic             i_or_d,
    output logic             ir_write,
    output logic             pc_en,
    output logic [1:0]       pc_source,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             halted,
    output logic [1:0]       fault,
    output logic [CNT_W-1:0] retired
);

    state_t             state_q, state_d;
    logic [1:0]         fault_q, fault_d;
    logic [CNT_W-1:0]   retired_q, retired_d;
    logic               retire;
    logic               wait_cyc;
    logic               tmo;

    assign wait_cyc = (state_q == S_FETCH || state_q == S_MEM_RD || state_q == S_MEM_WR)
                      && !mem_ready;

    // Counter clears whenever no stall is in progress, which covers entry to each wait state.
    mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
        .clk_i     (clk),
        .rst_i     (reset),
        .clear_i   (!wait_cyc),
        .inc_i     (wait_cyc),
        .expired_o (tmo)
    );

    always_comb begin
        state_d = state_q;
        fault_d = fault_q;
        retire  = 1'b0;
        case (state_q)
            S_IDLE:     if (run) state_d = S_FETCH;
            S_FETCH: begin
                if (mem_ready)
                    state_d = S_DECODE;
                else if (tmo) begin
                    state_d = S_FAULT;
                    fault_d = FAULT_TIMEOUT;
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:     state_d = S_EXEC_R;
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_ADDI:      state_d = S_EXEC_I;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_HALT:      state_d = S_HALT;
                    default: begin
                        state_d = S_FAULT;
                        fault_d = FAULT_ILLEGAL;
                    end
                endcase
            end
            S_EXEC_R:   state_d = S_WB_R;
            S_EXEC_I:   state_d = S_WB_I;
            S_MEM_ADDR: state_d = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD: begin
                if (mem_ready)
                    state_d = S_WB_MEM;
                else if (tmo) begin
                    state_d = S_FAULT;
                    fault_d = FAULT_TIMEOUT;
                end
            end
            S_MEM_WR: begin
                if (mem_ready) begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end else if (tmo) begin
                    state_d = S_FAULT;
                    fault_d = FAULT_TIMEOUT;
                end
            end
            S_WB_R, S_WB_I, S_WB_MEM, S_BRANCH, S_JUMP: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_HALT, S_FAULT: state_d = state_q;
            default:         state_d = S_IDLE;
        endcase
        retired_d = retire ? retired_q + CNT_W'(1) : retired_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            fault_q   <= FAULT_NONE;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            fault_q   <= fault_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        i_or_d     = 1'b0;
        ir_write   = 1'b0;
        pc_en      = 1'b0;
        pc_source  = PCSRC_ALU;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_REGB;
        alu_op     = ALU_ADD;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_ONE;
                ir_write  = mem_ready;
                pc_en     = mem_ready;
            end
            S_DECODE:   alu_src_b = SRCB_IMM;
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_FUNCT;
            end
            S_EXEC_I, S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            S_WB_R: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_WB_I:     reg_write = 1'b1;
            S_MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            S_WB_MEM: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_SUB;
                pc_source = PCSRC_ALUOUT;
                pc_en     = zero;
            end
            S_JUMP: begin
                pc_source = PCSRC_JUMP;
                pc_en     = 1'b1;
            end
            default: ;
        endcase
    end

    assign halted  = (state_q == S_HALT);
    assign fault   = fault_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_cpu16_mc_ctrl.sv
// Scoreboard bench for cpu16_mc_ctrl: an instruction-plan reference model
// pushes expected per-cycle outputs, a negedge monitor pops and compares.
module tb_cpu16_mc_ctrl;

    localparam int TMO = 4;
    localparam int CW  = 4;

    logic          clk, reset, run, zero, mem_ready;
    logic [3:0]    opcode;
    logic          mem_read, mem_write, i_or_d, ir_write, pc_en;
    logic [1:0]    pc_source, alu_src_b, alu_op, fault;
    logic          alu_src_a, reg_write, reg_dst, mem_to_reg, halted;
    logic [CW-1:0] retired;

    cpu16_mc_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .run(run), .opcode(opcode), .zero(zero),
        .mem_ready(mem_ready), .mem_read(mem_read), .mem_write(mem_write),
        .i_or_d(i_or_d), .ir_write(ir_write), .pc_en(pc_en),
        .pc_source(pc_source), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .reg_write(reg_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .halted(halted), .fault(fault),
        .retired(retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic mr, mw, iod, irw, pce;
        logic [1:0] pcs;
        logic asa;
        logic [1:0] asb, aop;
        logic rw, rd, m2r;
    } ctl_t;

    typedef struct packed {
        ctl_t c;
        logic halted;
        logic [1:0] fault;
        logic [CW-1:0] ret;
    } obs_t;

    // act: 0 continue, 1 enter halt, 2 illegal-opcode fault
    typedef struct {
        ctl_t c;
        bit   wmem;
        bit   pcz;
        bit   retire;
        int   act;
    } step_t;

    step_t plan[$];
    obs_t  expq[$];

    int mode;          // 0 idle, 1 running, 2 halted, 3 faulted
    logic [1:0] mfault;
    int mret;
    int waits;
    int total = 0;
    int bad = 0;
    int ncyc = 0;

    task automatic add(input ctl_t c, input bit w, input bit z, input bit r, input int a);
        step_t s;
        s.c = c; s.wmem = w; s.pcz = z; s.retire = r; s.act = a;
        plan.push_back(s);
    endtask

    function automatic bit legal(input logic [3:0] op);
        return op == 4'h0 || op == 4'h4 || op == 4'h5 || op == 4'h6 ||
               op == 4'h7 || op == 4'h8 || op == 4'hF;
    endfunction

    task automatic build_plan(input logic [3:0] op);
        ctl_t c;
        plan.delete();
        c = '0; c.mr = 1; c.asb = 2'b01; c.irw = 1; c.pce = 1;
        add(c, 1, 0, 0, 0);
        c = '0; c.asb = 2'b10;
        add(c, 0, 0, 0, (op == 4'hF) ? 1 : (legal(op) ? 0 : 2));
        case (op)
            4'h0: begin
                c = '0; c.asa = 1; c.aop = 2'b10; add(c, 0, 0, 0, 0);
                c = '0; c.rw = 1; c.rd = 1;       add(c, 0, 0, 1, 0);
            end
            4'h7: begin
                c = '0; c.asa = 1; c.asb = 2'b10; add(c, 0, 0, 0, 0);
                c = '0; c.rw = 1;                 add(c, 0, 0, 1, 0);
            end
            4'h4: begin
                c = '0; c.asa = 1; c.asb = 2'b10; add(c, 0, 0, 0, 0);
                c = '0; c.mr = 1; c.iod = 1;      add(c, 1, 0, 0, 0);
                c = '0; c.rw = 1; c.m2r = 1;      add(c, 0, 0, 1, 0);
            end
            4'h5: begin
                c = '0; c.asa = 1; c.asb = 2'b10; add(c, 0, 0, 0, 0);
                c = '0; c.mw = 1; c.iod = 1;      add(c, 1, 0, 1, 0);
            end
            4'h6: begin
                c = '0; c.asa = 1; c.aop = 2'b01; c.pcs = 2'b01; add(c, 0, 1, 1, 0);
            end
            4'h8: begin
                c = '0; c.pcs = 2'b10; c.pce = 1; add(c, 0, 0, 1, 0);
            end
            default: ;
        endcase
    endtask

    task automatic cycle(input logic r_run, input logic [3:0] op, input logic rdy,
                         input logic z, input logic rst);
        obs_t  e;
        step_t s;
        @(posedge clk); #1;
        run = r_run; opcode = op; mem_ready = rdy; zero = z; reset = rst;
        e = '0;
        if (rst) begin
            mode = 0; mret = 0; mfault = 2'b00; waits = 0; plan.delete();
        end else begin
            e.ret   = CW'(mret);
            e.fault = mfault;
            case (mode)
                0: if (r_run) mode = 1;
                2: e.halted = 1'b1;
                1: begin
                    if (plan.size() == 0) build_plan(op);
                    s = plan[0];
                    e.c = s.c;
                    if (s.wmem && !rdy) begin
                        e.c.irw = 0; e.c.pce = 0;
                        waits++;
                        if (waits == TMO) begin
                            mode = 3; mfault = 2'b10; waits = 0; plan.delete();
                        end
                    end else begin
                        if (s.pcz) e.c.pce = z;
                        if (s.retire) mret = (mret + 1) % (1 << CW);
                        waits = 0;
                        void'(plan.pop_front());
                        if (s.act == 1) begin mode = 2; plan.delete(); end
                        if (s.act == 2) begin mode = 3; mfault = 2'b01; plan.delete(); end
                    end
                end
                default: ;
            endcase
        end
        expq.push_back(e);
    endtask

    initial begin : monitor
        obs_t a, e;
        forever begin
            @(negedge clk);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                a.c.mr = mem_read;   a.c.mw = mem_write; a.c.iod = i_or_d;
                a.c.irw = ir_write;  a.c.pce = pc_en;    a.c.pcs = pc_source;
                a.c.asa = alu_src_a; a.c.asb = alu_src_b; a.c.aop = alu_op;
                a.c.rw = reg_write;  a.c.rd = reg_dst;   a.c.m2r = mem_to_reg;
                a.halted = halted;   a.fault = fault;    a.ret = retired;
                total++;
                if (a !== e) begin
                    bad++;
                    $display("FAIL outputs cyc=%0d got=%b want=%b (ctl|halted|fault|retired)",
                             ncyc, a, e);
                end
                ncyc++;
            end
        end
    end

    function automatic logic [3:0] rand_op();
        int r;
        logic [3:0] ill [6];
        logic [3:0] ok [6];
        ill = '{4'h1, 4'h2, 4'h3, 4'h9, 4'hA, 4'hE};
        ok  = '{4'h0, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8};
        r = $urandom_range(0, 99);
        if (r < 3) return ill[$urandom_range(0, 5)];
        if (r < 5) return 4'hF;
        return ok[$urandom_range(0, 5)];
    endfunction

    initial begin : stim
        logic [3:0] cur;
        int nr;
        reset = 1'b1; run = 1'b0; opcode = '0; zero = 1'b0; mem_ready = 1'b1;
        mode = 0; mret = 0; mfault = 2'b00; waits = 0;

        cycle(0, 4'h0, 1, 0, 1);
        cycle(0, 4'h0, 1, 0, 0);
        // R-type, zero wait
        cycle(1, 4'h0, 1, 0, 0);
        repeat (4) cycle(0, 4'h0, 1, 0, 0);
        // LW with three stall cycles in the data read
        repeat (3) cycle(0, 4'h4, 1, 0, 0);
        repeat (3) cycle(0, 4'h4, 0, 0, 0);
        repeat (2) cycle(0, 4'h4, 1, 0, 0);
        // BEQ taken then not taken
        repeat (3) cycle(0, 4'h6, 1, 1, 0);
        repeat (3) cycle(0, 4'h6, 1, 0, 0);
        // ADDI, then enough jumps to wrap the retired counter
        repeat (4) cycle(0, 4'h7, 1, 0, 0);
        repeat (14 * 3) cycle(0, 4'h8, 1, 0, 0);
        // SW interrupted by reset while the write is stalled
        repeat (3) cycle(0, 4'h5, 1, 0, 0);
        cycle(0, 4'h5, 0, 0, 0);
        cycle(0, 4'h5, 0, 0, 1);
        cycle(0, 4'h5, 1, 0, 0);
        // fetch timeout
        cycle(1, 4'h0, 1, 0, 0);
        repeat (TMO) cycle(0, 4'h0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cycle(1'(i), 4'h0, 1, 0, 0);
        cycle(0, 4'h0, 1, 0, 1);
        // illegal opcode
        cycle(1, 4'h3, 1, 0, 0);
        repeat (5) cycle(0, 4'h3, 1, 0, 0);
        cycle(0, 4'h0, 1, 0, 1);
        // halt, run toggling ignored
        cycle(1, 4'hF, 1, 0, 0);
        cycle(0, 4'hF, 1, 0, 0);
        for (int i = 0; i < 5; i++) cycle(1'(i), 4'hF, 1, 0, 0);
        cycle(0, 4'h0, 1, 0, 1);

        // randomized episodes
        for (int ep = 0; ep < 30; ep++) begin
            cycle(0, 4'h0, 1, 0, 1);
            cur = rand_op();
            for (int c = 0; c < 60; c++) begin
                if (plan.size() == 0) cur = rand_op();
                case (ep % 3)
                    0:       nr = ($urandom_range(0, 3) == 0) ? 0 : 1;
                    1:       nr = ($urandom_range(0, 1) == 0) ? 0 : 1;
                    default: nr = ($urandom_range(0, 7) == 0) ? 0 : 1;
                endcase
                cycle(1'($urandom_range(0, 1)), cur, 1'(nr), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 79) == 0));
            end
        end

        repeat (2) @(posedge clk);
        total++;
        if (expq.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain got=%0d want=0", expq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cpu16_mc_ctrl.md
Name: cpu16_mc_ctrl

Overview:
- Multi-cycle control FSM that sequences the 16-bit CPU datapath through fetch, decode, execute, memory and writeback.
- Replaces the single-cycle combinational control unit.
- Drives per-cycle datapath enables and muxes from the opcode and the ALU zero flag.
- Handshakes with one shared instruction/data memory via mem_ready, with a timeout and a fault state.

Parameters:
- MEM_TIMEOUT, 8: consecutive not-ready cycles in one memory access that trigger a fault (legal range 2..255).
- CNT_W, 16: width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- run  in  1  leave IDLE and begin fetching
- opcode  in  4  instruction[15:12] from the IR
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut
- ir_write  out  1  load the IR
- pc_en  out  1  PC load enable (already combined with zero for branches)
- pc_source  out  2  next-PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = regA
- alu_src_b  out  2  ALU B select: 00 = regB, 01 = const 1, 10 = sign-extended imm
- alu_op  out  2  ALU operation: 00 = add, 01 = sub, 10 = decode funct
- reg_write  out  1  register-file write
- reg_dst  out  1  destination register: 0 = rt, 1 = rd
- mem_to_reg  out  1  writeback select: 0 = ALUOut, 1 = MDR
- halted  out  1  FSM in HALT
- fault  out  2  fault code: 00 none, 01 illegal opcode, 10 memory timeout
- retired  out  CNT_W  count of completed instructions

Behaviour:
- Reset (asynchronous):
  - State goes to IDLE; retired = 0; fault = 00; wait counter = 0.
  - All control outputs are 0 while reset is high and while in IDLE.
- Opcodes:
  - 0000 R-type, 0100 LW, 0101 SW, 0110 BEQ, 0111 ADDI, 1000 J, 1111 HALT.
  - Any other opcode is illegal.
- States and transitions:
  - IDLE -> FETCH when run = 1.
  - FETCH: mem_read = 1, i_or_d = 0, alu_src_a = 0, alu_src_b = 01, alu_op = 00, pc_source = 00.
    - ir_write and pc_en are asserted only in the cycle mem_ready = 1; the FSM then goes to DECODE, otherwise it holds.
  - DECODE: alu_src_a = 0, alu_src_b = 10, alu_op = 00 (branch target precomputed into ALUOut). Next state by opcode:
    - R-type -> EXEC_R
    - LW, SW -> MEM_ADDR
    - ADDI -> EXEC_I
    - BEQ -> BRANCH
    - J -> JUMP
    - HALT -> HALT
    - illegal -> FAULT with fault = 01
  - EXEC_R: alu_src_a = 1, alu_src_b = 00, alu_op = 10. -> WB_R.
  - WB_R: reg_write = 1, reg_dst = 1, mem_to_reg = 0. -> FETCH.
  - EXEC_I: alu_src_a = 1, alu_src_b = 10, alu_op = 00. -> WB_I.
  - WB_I: reg_write = 1, reg_dst = 0, mem_to_reg = 0. -> FETCH.
  - MEM_ADDR: same ALU controls as EXEC_I. -> MEM_RD for LW, MEM_WR for SW.
  - MEM_RD: mem_read = 1, i_or_d = 1. Holds until mem_ready = 1, then -> WB_MEM.
  - WB_MEM: reg_write = 1, reg_dst = 0, mem_to_reg = 1. -> FETCH.
  - MEM_WR: mem_write = 1, i_or_d = 1. Holds until mem_ready = 1, then -> FETCH.
  - BRANCH: alu_src_a = 1, alu_src_b = 00, alu_op = 01, pc_source = 01. pc_en = zero (combinational). -> FETCH.
  - JUMP: pc_source = 10, pc_en = 1. -> FETCH.
  - HALT: halted = 1. Terminal until reset; run is ignored.
  - FAULT: all enables 0; fault is held. Terminal until reset.
- Memory wait:
  - The wait counter clears on entry to FETCH, MEM_RD or MEM_WR.
  - It increments each cycle in those states with mem_ready = 0.
  - Timeout: the MEM_TIMEOUT-th consecutive not-ready cycle moves the FSM to FAULT with fault = 10. No IR, PC or register write occurs.
  - mem_ready = 1 on that same cycle wins: the access completes normally.
- Retired counter:
  - Increments on the final cycle of each instruction: WB_R, WB_I, WB_MEM, BRANCH, JUMP, and MEM_WR with mem_ready = 1.
  - Wraps at all-ones to 0.
  - HALT and FAULT do not count.
- Latency with zero wait states:
  - R-type, ADDI and SW: 4 cycles.
  - LW: 5 cycles.
  - BEQ and J: 3 cycles.
- Reset mid-operation: immediate return to IDLE. An in-flight memory request drops in the same cycle.

Decomposition:
- Shared package cpu16_pkg holds:
  - opcode constants
  - state enum
  - alu_op, alu_src_b and pc_source encodings
  - fault codes
- Optional sub-module mem_wait_timer: counter plus timeout compare, with clear, inc and expired ports.

Test Plan:
- Reset, then run = 1, opcode = 0000, mem_ready tied 1.
  - Required: exact 4-cycle sequence FETCH, DECODE, EXEC_R, WB_R.
  - Required: reg_write = 1 and reg_dst = 1 in cycle 4; retired = 1.
- LW with mem_ready low for 3 cycles in MEM_RD (MEM_TIMEOUT = 8).
  - Required: mem_read and i_or_d held high for 4 cycles.
  - Required: WB_MEM asserts mem_to_reg = 1; total 8 cycles.
- BEQ twice: first with zero = 1, then zero = 0.
  - Required: pc_en = 1 with pc_source = 01 in BRANCH for the first; pc_en = 0 for the second.
  - Required: retired increments in both cases.
- MEM_TIMEOUT = 4, mem_ready held 0 in FETCH.
  - Required: fault = 10 after 4 cycles; ir_write never asserted.
  - Required: the FSM stays in FAULT until reset.
- Opcode 0011 in DECODE -> fault = 01. Opcode 1111 -> halted = 1, retired unchanged, and toggling run has no effect.
- reset asserted mid-MEM_WR -> mem_write drops in the same cycle; all outputs 0; retired = 0.
